// File: rtl/ysyx_22041752_imem_resp.sv
// ---------------------------------------------------------------------------
// ysyx_22041752_imem_resp
//
// Instruction-memory responder for the fetch stage. After reset it sits in
// BOOT and accepts a stream of 32-bit words on the boot port, writing them to
// consecutive entries of a local word-addressed store. After the last word
// (boot_last, or the store is full), it moves to RUN. In RUN it answers every
// accepted fetch with registered read data on the next cycle. That data is
// held until the next accepted fetch.
//
// Optional feature: define YSYX_22041752_IMEM_PARITY_EN to store an even-parity
// bit with every entry. That build checks the parity on each in-range fetch and
// adds the sticky error output imem_par_err.
//
// Ports:
//   clk           sole clock, rising edge
//   reset         asynchronous, active-low reset
//   inst_en       fetch strobe (accepted when inst_ready=1)
//   inst_addr     fetch byte address (bits [1:0] ignored)
//   inst_ready    high in RUN: a fetch can be accepted this cycle
//   inst_rdata    registered read data; [31:0] instruction, upper bits zero
//   boot_valid    boot word present
//   boot_data     boot word
//   boot_last     marks the final boot word
//   boot_ready    high in BOOT: boot words are accepted
//   boot_done     high once in RUN
//   imem_par_err  (parity build only) sticky parity mismatch flag
// ---------------------------------------------------------------------------
module ysyx_22041752_imem_resp #(
    parameter int                 ADDR_WD    = 32,
    parameter int                 DATA_WD    = 64,
    parameter int                 DEPTH_LOG2 = 10,
    parameter logic [ADDR_WD-1:0] BASE_ADDR  = 32'h8000_0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inst_en,
    input  logic [ADDR_WD-1:0] inst_addr,
    output logic               inst_ready,
    output logic [DATA_WD-1:0] inst_rdata,
    input  logic               boot_valid,
    input  logic [31:0]        boot_data,
    input  logic               boot_last,
    output logic               boot_ready,
    output logic               boot_done
`ifdef YSYX_22041752_IMEM_PARITY_EN
    ,
    output logic               imem_par_err
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

`ifdef YSYX_22041752_IMEM_PARITY_EN
    localparam int ENTRY_WD = 33;   // {parity, word}
`else
    localparam int ENTRY_WD = 32;
`endif

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                state_reg, state_next;
    logic [DEPTH_LOG2-1:0] wr_idx_reg, wr_idx_next;
    logic                  boot_fire;
    logic                  fetch_fire;

    logic [ENTRY_WD-1:0]   mem_reg [DEPTH];
    logic [ENTRY_WD-1:0]   wr_entry;
    logic [ENTRY_WD-1:0]   rd_entry_reg;
    logic                  rd_in_range_reg;

    logic [ADDR_WD-1:0]    word_off;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic                  in_range;

    // Handshake strobes. The ready outputs are pure decodes of state_reg, so
    // neither has a combinational path from any input.
    assign boot_ready = (state_reg == ST_BOOT);
    assign inst_ready = (state_reg == ST_RUN);
    assign boot_done  = (state_reg == ST_RUN);
    assign boot_fire  = boot_valid && boot_ready;
    assign fetch_fire = inst_en && inst_ready;

    // ------------------------------------------------------------------
    // FSM: state register and boot write index
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= ST_BOOT;
            wr_idx_reg <= '0;
        end else begin
            state_reg  <= state_next;
            wr_idx_reg <= wr_idx_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        wr_idx_next = wr_idx_reg;
        if (state_reg == ST_BOOT && boot_fire) begin
            // The final entry ends the boot even without boot_last.
            // In that case the index is held rather than wrapped.
            if (boot_last || (&wr_idx_reg)) begin
                state_next = ST_RUN;
            end else begin
                wr_idx_next = wr_idx_reg + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Instruction store: write port from boot, registered read for fetch.
    // The store has no reset, so a mid-boot reset leaves old contents in
    // place until the next boot overwrites them.
    // ------------------------------------------------------------------
`ifdef YSYX_22041752_IMEM_PARITY_EN
    assign wr_entry = {^boot_data, boot_data};   // even parity over all 33 bits
`else
    assign wr_entry = boot_data;
`endif

    always_ff @(posedge clk) begin
        if (boot_fire) begin
            mem_reg[wr_idx_reg] <= wr_entry;
        end
    end

    // The word offset relative to BASE_ADDR wraps modulo 2^ADDR_WD. For an
    // address below the base, that gives a large offset, but the explicit
    // compare rejects it anyway.
    assign word_off = (inst_addr - BASE_ADDR) >> 2;
    assign rd_idx   = word_off[DEPTH_LOG2-1:0];
    assign in_range = (inst_addr >= BASE_ADDR) && ((word_off >> DEPTH_LOG2) == '0);

    always_ff @(posedge clk) begin
        if (fetch_fire) begin
            rd_entry_reg <= mem_reg[rd_idx];
        end
    end

    // rd_in_range_reg gates the read data. Reset clears it, which forces
    // inst_rdata to zero immediately without resetting the RAM output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_in_range_reg <= 1'b0;
        end else if (fetch_fire) begin
            rd_in_range_reg <= in_range;
        end
    end

    assign inst_rdata = {{(DATA_WD-32){1'b0}},
                         (rd_in_range_reg ? rd_entry_reg[31:0] : 32'h0)};

`ifdef YSYX_22041752_IMEM_PARITY_EN
    // ------------------------------------------------------------------
    // Parity check. The check is taken on the registered entry, so it lines
    // up with inst_rdata. The sticky bit captures it, and the output ORs in
    // the live result so the flag rises in the same cycle as the bad data.
    // ------------------------------------------------------------------
    logic par_bad;
    logic par_sticky_reg;

    assign par_bad = rd_in_range_reg && (^rd_entry_reg);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_sticky_reg <= 1'b0;
        end else if (par_bad) begin
            par_sticky_reg <= 1'b1;
        end
    end

    assign imem_par_err = par_sticky_reg || par_bad;
`endif

endmodule
